// File: rtl/mem_32_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM.
// A host port and a local-engine port share the RAM. Grants are decided
// combinationally each cycle, and an owner may keep the RAM for up to
// BURST_MAX consecutive grants while the other side is waiting. Read data
// returns one cycle after a granted read, and the matching rvalid strobe
// tells each side which read result is on rdata.
module mem_32_arbiter #(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter int BURST_MAX = 4
) (
    input  logic              bus_clk,
    input  logic              bus_rst_n,
    input  logic              quiesce,
    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    output logic              h_gnt,
    output logic              h_rvalid,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       conflict_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOST  = 2'd1,
        LOCAL = 2'd2
    } state_t;

    localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

    state_t      state_reg;
    state_t      state_next;
    logic        last_host_reg;   // 1: host was served last, 0: local was
    logic [3:0]  burst_cnt_reg;
    logic [3:0]  burst_cnt_next;
    logic [15:0] conflict_cnt_reg;
    logic        h_rvalid_reg;
    logic        l_rvalid_reg;
    logic        hr;

    // A quiesced host link cannot request.
    assign hr = h_req & ~quiesce;

    // Grant decision and next state. The current owner keeps the RAM while it
    // requests, unless its burst is exhausted and the other side is waiting.
    // Grants are held off while reset is asserted.
    always_comb begin
        h_gnt = 1'b0;
        l_gnt = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (hr && l_req) begin
                    if (last_host_reg) l_gnt = 1'b1;
                    else               h_gnt = 1'b1;
                end else if (hr) begin
                    h_gnt = 1'b1;
                end else if (l_req) begin
                    l_gnt = 1'b1;
                end
            end
            HOST: begin
                if (hr && ((burst_cnt_reg < BURST_LIM) || !l_req)) h_gnt = 1'b1;
                else if (l_req)                                     l_gnt = 1'b1;
            end
            LOCAL: begin
                if (l_req && ((burst_cnt_reg < BURST_LIM) || !hr)) l_gnt = 1'b1;
                else if (hr)                                        h_gnt = 1'b1;
            end
            default: begin
                h_gnt = 1'b0;
                l_gnt = 1'b0;
            end
        endcase
        if (!bus_rst_n) begin
            h_gnt = 1'b0;
            l_gnt = 1'b0;
        end

        state_next     = IDLE;
        burst_cnt_next = 4'd0;
        if (h_gnt) begin
            state_next = HOST;
            if (state_reg != HOST)              burst_cnt_next = 4'd1;
            else if (burst_cnt_reg < BURST_LIM) burst_cnt_next = burst_cnt_reg + 4'd1;
            else                                burst_cnt_next = burst_cnt_reg;
        end else if (l_gnt) begin
            state_next = LOCAL;
            if (state_reg != LOCAL)             burst_cnt_next = 4'd1;
            else if (burst_cnt_reg < BURST_LIM) burst_cnt_next = burst_cnt_reg + 4'd1;
            else                                burst_cnt_next = burst_cnt_reg;
        end
    end

    // Route the granted side onto the RAM port; park everything at zero otherwise.
    always_comb begin
        mem_en    = h_gnt | l_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (h_gnt) begin
            mem_we    = h_we;
            mem_addr  = h_addr;
            mem_wdata = h_wdata;
        end else if (l_gnt) begin
            mem_we    = l_we;
            mem_addr  = l_addr;
            mem_wdata = l_wdata;
        end
    end

    // Arbitration state, burst length, ownership history and read-return tags.
    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            state_reg     <= IDLE;
            last_host_reg <= 1'b0;
            burst_cnt_reg <= 4'd0;
            h_rvalid_reg  <= 1'b0;
            l_rvalid_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            burst_cnt_reg <= burst_cnt_next;
            if (h_gnt)      last_host_reg <= 1'b1;
            else if (l_gnt) last_host_reg <= 1'b0;
            h_rvalid_reg  <= h_gnt & ~h_we;
            l_rvalid_reg  <= l_gnt & ~l_we;
        end
    end

    // Saturating count of cycles in which one requester was made to wait.
    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            conflict_cnt_reg <= 16'd0;
        end else if (hr && l_req && (h_gnt ^ l_gnt) && (conflict_cnt_reg != 16'hFFFF)) begin
            conflict_cnt_reg <= conflict_cnt_reg + 16'd1;
        end
    end

    assign h_rvalid     = h_rvalid_reg;
    assign l_rvalid     = l_rvalid_reg;
    assign rdata        = mem_rdata;
    assign conflict_cnt = conflict_cnt_reg;

endmodule
